serial_frame_tx: RTL and testbench
==================================

# serial_frame_tx

Serializing transmitter that produces the single-bit framed stream our serial-controlled state machines consume on their `in` line. It accepts one parallel word through a valid/ready handshake and sends it as one frame:
- a run of preamble `1` bits,
- the data bits, MSB first,
- a run of `0` gap bits that returns the line to idle.

It sits between a parallel producer (register block or test sequencer) and the serial consumer FSM.

## Interface
Parameters:
- `DATA_W`, 8: payload width in bits; minimum 1.
- `PRE_CYCLES`, 2: preamble length in cycles, `tx_bit`=1; minimum 1.
- `GAP_CYCLES`, 2: trailing gap length in cycles, `tx_bit`=0; minimum 1.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  DATA_W  payload; sampled only on accept.
- `data_valid`  in  1  producer has a word.
- `data_ready`  out  1  block can accept a word.
- `tx_bit`  out  1  serial output line.
- `tx_busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse on the last cycle of a frame.

## Operation
- States: IDLE, PREAMBLE, DATA, GAP.
- All outputs are registered, driven from flops with no combinational path from inputs.
- Reset (`reset_n`=0, asynchronous) forces:
  - state IDLE;
  - `tx_bit`=0, `tx_busy`=0, `done`=0, `data_ready`=0;
  - shift register and counter to 0.
- On the first clock edge after reset release: `data_ready`=1.
- **Accept:** a word is accepted on a rising edge where state is IDLE and `data_valid`=1 and `data_ready`=1.
  - `data_in` is captured into the shift register.
  - `data_valid` is ignored while `data_ready`=0.
  - `data_in` changes after accept have no effect.
- **IDLE:**
  - `tx_bit`=0, `tx_busy`=0, `data_ready`=1.
  - Goes to PREAMBLE on accept; otherwise holds.
- **PREAMBLE:**
  - `tx_bit`=1 for exactly `PRE_CYCLES` cycles.
  - Then goes to DATA.
- **DATA:**
  - `tx_bit` = shift register MSB.
  - Shift left by one per cycle, exactly `DATA_W` cycles.
  - Then goes to GAP.
- **GAP:**
  - `tx_bit`=0 for exactly `GAP_CYCLES` cycles.
  - `done`=1 on the final GAP cycle only.
  - Then goes to IDLE.
- `tx_busy`=1 and `data_ready`=0 in PREAMBLE, DATA and GAP.
- **Counter:** one shared down-counter, width `$clog2(max(PRE_CYCLES, DATA_W, GAP_CYCLES)+1)`.
  - Loaded with (phase length − 1) on entry to each phase.
  - The phase ends when the counter reads 0.
  - No wrap-around is permitted.
- Unreachable state encodings go to IDLE on the next edge, with outputs at IDLE values.

## Timing
- Let edge E0 be the accept edge, and cycle k be the cycle following edge E0+k−1.
- Cycle 1 is the first cycle after E0.
- Frame length: F = `PRE_CYCLES` + `DATA_W` + `GAP_CYCLES` cycles.
  - Cycles 1..PRE_CYCLES: preamble.
  - Cycles PRE_CYCLES+1 .. PRE_CYCLES+DATA_W: data, MSB first.
  - Cycles up to F: gap.
- `done` is high in cycle F only.
- `data_ready` rises in cycle F+1.
- Back-to-back frames: if `data_valid` is held high, the next accept occurs at the edge ending cycle F+1, and that frame's preamble starts in cycle F+2.
  - Minimum idle between frames is one cycle with `tx_bit`=0, plus the gap.
- Latency from accept edge to first preamble bit: 1 cycle.
- Reset mid-frame:
  - Outputs go to reset values immediately, without waiting for a clock.
  - The in-flight word is discarded and no `done` is produced.
  - After release, `data_ready`=1 at the first edge.
- `data_valid` rising in the same cycle as `done`: no accept, because `data_ready`=0; it is accepted in cycle F+1.

## Test plan
1. **Reset values.** Assert `reset_n`=0 mid-cycle → all outputs 0 asynchronously. Release → `data_ready`=1 after the first edge.
2. **Single frame.** With `DATA_W`=8, `PRE_CYCLES`=2, `GAP_CYCLES`=2, accept 0xA5.
   - `tx_bit` over cycles 1–12 = 1,1,1,0,1,0,0,1,0,1,0,0.
   - `tx_busy`=1 in cycles 1–12; `done` high in cycle 12 only; `data_ready`=1 in cycle 13.
3. **Back-to-back frames.** Hold `data_valid`=1 with 0xFF then 0x00.
   - Second accept at the end of cycle 13; second preamble in cycles 14–15.
   - Data bits all 0 in cycles 16–23.
   - `done` pulses in cycles 12 and 25.
4. **Input stability.** Change `data_in` to 0x3C during the 0xA5 frame → serialized bits still equal 0xA5. Assert `data_valid` while busy → no extra frame is produced.
5. **Reset mid-frame.** Assert `reset_n`=0 in cycle 6 of a 0x81 frame → `tx_bit`=0 and `tx_busy`=0 immediately, no `done`. The next accepted word 0x81 is sent complete and correct.
6. **Parameter corners.** `DATA_W`=1, `PRE_CYCLES`=1, `GAP_CYCLES`=1, accept 1 → `tx_bit` = 1,1,0 over cycles 1–3; `done` in cycle 3; `data_ready` in cycle 4.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serializes one parallel word per handshake into a framed
// single-bit stream: PRE_CYCLES preamble 1s, DATA_W data bits MSB first, then
// GAP_CYCLES 0s that return the line to idle.
//
// Handshake: a word is accepted on a rising edge where the FSM is in IDLE,
// data_valid=1 and data_ready=1. data_ready is a registered output, so
// data_valid is ignored whenever data_ready=0. data_in is sampled only on that
// edge; later changes to data_in do not affect the frame in flight.
//
// Every output comes from a flop. The comb block computes the next state and
// the value each output must show in the next cycle, and a single register
// stage applies both together. state_dbg mirrors the state register so that
// checkers can observe the FSM.
module serial_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int PRE_CYCLES = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_bit,
  output logic              tx_busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  // One shared down-counter sized for the longest phase.
  localparam int MAX_PD  = (PRE_CYCLES > DATA_W) ? PRE_CYCLES : DATA_W;
  localparam int MAX_LEN = (MAX_PD > GAP_CYCLES) ? MAX_PD : GAP_CYCLES;
  localparam int CW      = (MAX_LEN < 1) ? 1 : $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_bit_d, tx_busy_d, done_d, data_ready_d;
  logic              accept;

  assign state_dbg = state_q;

  // Next-state, counter, shift register and next-cycle output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    tx_bit_d = 1'b0;
    accept   = (state_q == IDLE) && data_valid && data_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PREAMBLE;
          cnt_d    = PRE_LOAD;
          shreg_d  = data_in;
          tx_bit_d = 1'b1;
        end else begin
          cnt_d = '0;
        end
      end
      PREAMBLE: begin
        if (cnt_q == '0) begin
          // The first data bit goes out in the cycle after the last preamble bit.
          state_d  = DATA;
          cnt_d    = DATA_LOAD;
          tx_bit_d = shreg_q[DATA_W-1];
          shreg_d  = shreg_q << 1;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          tx_bit_d = 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          state_d  = GAP;
          cnt_d    = GAP_LOAD;
          tx_bit_d = 1'b0;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          tx_bit_d = shreg_q[DATA_W-1];
          shreg_d  = shreg_q << 1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        shreg_d = '0;
      end
    endcase

    tx_busy_d    = (state_d != IDLE);
    data_ready_d = (state_d == IDLE);
    // done marks the final gap cycle: the gap phase with the counter at 0.
    done_d       = (state_d == GAP) && (cnt_d == '0);
  end

  // State, datapath and registered outputs; asynchronous reset clears them all.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      tx_bit     <= 1'b0;
      tx_busy    <= 1'b0;
      done       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      tx_bit     <= tx_bit_d;
      tx_busy    <= tx_busy_d;
      done       <= done_d;
      data_ready <= data_ready_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed bench for serial_frame_tx. Inputs are driven and
// outputs are sampled on the falling edge, away from the active rising edge.
module tb_serial_frame_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT: DATA_W=8, PRE=2, GAP=2
  logic [7:0] data_in = '0;
  logic       data_valid = 1'b0;
  logic       data_ready, tx_bit, tx_busy, done;
  logic [1:0] state_dbg;

  serial_frame_tx #(.DATA_W(8), .PRE_CYCLES(2), .GAP_CYCLES(2)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx_bit     (tx_bit),
    .tx_busy    (tx_busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // corner DUT: DATA_W=1, PRE=1, GAP=1
  logic [0:0] s_data_in = '0;
  logic       s_valid = 1'b0;
  logic       s_ready, s_tx_bit, s_busy, s_done;
  logic [1:0] s_state_dbg;

  serial_frame_tx #(.DATA_W(1), .PRE_CYCLES(1), .GAP_CYCLES(1)) u_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (s_data_in),
    .data_valid (s_valid),
    .data_ready (s_ready),
    .tx_bit     (s_tx_bit),
    .tx_busy    (s_busy),
    .done       (s_done),
    .state_dbg  (s_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected tx_bit for cycle k (1..12) of an 8-bit frame.
  function automatic logic model_bit(input logic [7:0] w, input int k);
    if (k <= 2)       return 1'b1;
    else if (k <= 10) return w[10-k];
    else              return 1'b0;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge with the DUT idle and ready. Returns at the
  // falling edge of cycle F+1 (13) after checking it.
  // mode 0: plain frame; mode 1: change data_in and raise data_valid while busy;
  // mode 2: keep data_valid high for a back-to-back follow-up.
  task automatic run_frame(input logic [7:0] w, input int mode, output logic [11:0] bits);
    bits = '0;
    data_in    = w;
    data_valid = 1'b1;
    @(negedge clk);
    if (mode != 2) data_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      bits = {bits[10:0], tx_bit};
      check($sformatf("f%0h_m%0d_tx_c%0d", w, mode, k), tx_bit, model_bit(w, k));
      check($sformatf("f%0h_m%0d_busy_c%0d", w, mode, k), tx_busy, 1'b1);
      check($sformatf("f%0h_m%0d_done_c%0d", w, mode, k), done, (k == 12));
      check($sformatf("f%0h_m%0d_ready_c%0d", w, mode, k), data_ready, 1'b0);
      if (mode == 1 && k == 3) begin
        data_in    = 8'h3C;
        data_valid = 1'b1;
      end
      if (mode == 1 && k == 10) data_valid = 1'b0;
      @(negedge clk);
    end
    check($sformatf("f%0h_m%0d_ready_c13", w, mode), data_ready, 1'b1);
    check($sformatf("f%0h_m%0d_busy_c13", w, mode), tx_busy, 1'b0);
    check($sformatf("f%0h_m%0d_tx_c13", w, mode), tx_bit, 1'b0);
    check($sformatf("f%0h_m%0d_done_c13", w, mode), done, 1'b0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] bits;

    // Hand-computed serial streams, cycles 1..12, first bit in the MSB.
    exp_q.push_back(12'hE94); // 0xA5 single frame
    exp_q.push_back(12'hE94); // 0xA5 with data_in changed mid-frame
    exp_q.push_back(12'hFFC); // 0xFF back-to-back first
    exp_q.push_back(12'hC00); // 0x00 back-to-back second
    exp_q.push_back(12'hE04); // 0x81 after mid-frame reset

    // 1. reset values
    repeat (2) @(negedge clk);
    check("rst_tx", tx_bit, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", data_ready, 1'b0);
    check("rst_small_ready", s_ready, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_ready", data_ready, 1'b1);
    check("rel_small_ready", s_ready, 1'b1);
    // asynchronous assertion in the middle of a cycle
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_ready", data_ready, 1'b0);
    check("async_busy", tx_busy, 1'b0);
    check("async_tx", tx_bit, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    check("rel2_ready_before_edge", data_ready, 1'b0);
    @(negedge clk);
    check("rel2_ready", data_ready, 1'b1);

    // 2. single frame 0xA5
    run_frame(8'hA5, 0, bits);
    check("a5_serial", bits, exp_q.pop_front());

    // 4. input stability: data_in changes and data_valid raised while busy
    run_frame(8'hA5, 1, bits);
    check("a5_stable_serial", bits, exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("no_extra_busy_%0d", i), tx_busy, 1'b0);
      check($sformatf("no_extra_tx_%0d", i), tx_bit, 1'b0);
    end

    // 3. back-to-back frames with data_valid held
    run_frame(8'hFF, 2, bits);
    check("ff_serial", bits, exp_q.pop_front());
    run_frame(8'h00, 0, bits);
    check("b2b_00_serial", bits, exp_q.pop_front());

    // 5. reset in cycle 6 of a 0x81 frame
    @(negedge clk);
    data_in    = 8'h81;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check("r81_tx_c1", tx_bit, 1'b1);
    for (int k = 2; k <= 6; k++) @(negedge clk);
    check("r81_busy_c6", tx_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("r81_async_tx", tx_bit, 1'b0);
    check("r81_async_busy", tx_busy, 1'b0);
    check("r81_async_ready", data_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("r81_no_done_%0d", i), done, 1'b0);
      check($sformatf("r81_idle_busy_%0d", i), tx_busy, 1'b0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check("r81_rel_ready", data_ready, 1'b1);
    run_frame(8'h81, 0, bits);
    check("r81_serial", bits, exp_q.pop_front());

    // 6. parameter corner: DATA_W=1, PRE=1, GAP=1, word 1
    s_data_in = 1'b1;
    s_valid   = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check("s_tx_c1", s_tx_bit, 1'b1);
    check("s_busy_c1", s_busy, 1'b1);
    check("s_done_c1", s_done, 1'b0);
    @(negedge clk);
    check("s_tx_c2", s_tx_bit, 1'b1);
    check("s_done_c2", s_done, 1'b0);
    @(negedge clk);
    check("s_tx_c3", s_tx_bit, 1'b0);
    check("s_busy_c3", s_busy, 1'b1);
    check("s_done_c3", s_done, 1'b1);
    check("s_ready_c3", s_ready, 1'b0);
    @(negedge clk);
    check("s_ready_c4", s_ready, 1'b1);
    check("s_busy_c4", s_busy, 1'b0);
    check("s_done_c4", s_done, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
